// File: rtl/apb_pkg.sv
// Shared state encoding and default geometry for the APB bridge.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
// Contents: apb_br_state_e, default bus widths, slave window base/size, timeout, idx_width().
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_br_state_e;

  localparam int          APB_ADDR_W    = 32;
  localparam int          APB_DATA_W    = 32;
  localparam logic [31:0] APB_BASE_ADDR = 32'h4000_0000;
  localparam int          APB_WIN_BITS  = 12;
  localparam int          APB_TIMEOUT   = 16;

  // Slave index width; a single slave still gets a 1-bit index so slices stay legal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Maps a byte address onto one of NUM_SLV equally sized slave windows.
// Latency: combinational, zero cycles.
// Backpressure: none; pure decode.
// Ports: cmd_addr (in) -> hit (address falls in an existing window), idx (window number).
module apb_addr_decode
  import apb_pkg::*;
#(
  parameter int                    ADDR_WIDTH = APB_ADDR_W,
  parameter int                    NUM_SLV    = 4,
  parameter int                    WIN_BITS   = APB_WIN_BITS,
  parameter int                    IDXW       = idx_width(NUM_SLV),
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = APB_BASE_ADDR
) (
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  output logic                  hit,
  output logic [IDXW-1:0]       idx
);

  localparam int TOPB = WIN_BITS + IDXW;

  // Offset inside a window never affects the decode.
  logic unused_offset;
  assign unused_offset = ^cmd_addr[WIN_BITS-1:0];

  assign idx = cmd_addr[WIN_BITS +: IDXW];

  // Region compare on the bits above the whole slave block; the index check
  // rejects the unpopulated tail when NUM_SLV is not a power of two.
  assign hit = (cmd_addr[ADDR_WIDTH-1:TOPB] == BASE_ADDR[ADDR_WIDTH-1:TOPB]) &&
               (int'(idx) < NUM_SLV);

endmodule

// File: rtl/apb_bridge_nport.sv
// APB4 requester: one command at a time from a valid/ready port to NUM_SLV peripherals.
// Latency: zero-wait slave gives psel +1, penable +2, rsp_valid +3 cycles after accept; +1 per wait state.
// Backpressure: cmd_ready low from accept until the response handshake; response held until rsp_ready.
// Ports: pclk/presetn; cmd_* command in; rsp_* response out; paddr/psel/penable/pwrite/pwdata/pstrb/pprot
//        shared APB request bus; prdata/pready/pslverr per-slave returns, only the selected slave observed.
module apb_bridge_nport
  import apb_pkg::*;
#(
  parameter int                    ADDR_WIDTH = APB_ADDR_W,
  parameter int                    DATA_WIDTH = APB_DATA_W,
  parameter int                    STRB_WIDTH = DATA_WIDTH / 8,
  parameter int                    NUM_SLV    = 4,
  parameter int                    WIN_BITS   = APB_WIN_BITS,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = APB_BASE_ADDR,
  parameter int                    TIMEOUT    = APB_TIMEOUT
) (
  input  logic                          pclk,
  input  logic                          presetn,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [ADDR_WIDTH-1:0]         cmd_addr,
  input  logic [DATA_WIDTH-1:0]         cmd_wdata,
  input  logic [STRB_WIDTH-1:0]         cmd_strb,
  input  logic [2:0]                    cmd_prot,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic [ADDR_WIDTH-1:0]         paddr,
  output logic [NUM_SLV-1:0]            psel,
  output logic                          penable,
  output logic                          pwrite,
  output logic [DATA_WIDTH-1:0]         pwdata,
  output logic [STRB_WIDTH-1:0]         pstrb,
  output logic [2:0]                    pprot,
  input  logic [NUM_SLV*DATA_WIDTH-1:0] prdata,
  input  logic [NUM_SLV-1:0]            pready,
  input  logic [NUM_SLV-1:0]            pslverr
);

  localparam int IDXW = idx_width(NUM_SLV);
  localparam int CNTW = $clog2(TIMEOUT);   // wait counter runs 0..TIMEOUT-1

  apb_br_state_e         state;
  logic [IDXW-1:0]       idx_q;
  logic [CNTW-1:0]       wcnt;

  logic                  dec_hit;
  logic [IDXW-1:0]       dec_idx;
  logic                  sel_ready;
  logic                  sel_err;
  logic [DATA_WIDTH-1:0] sel_rdata;

  apb_addr_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_SLV    (NUM_SLV),
    .WIN_BITS   (WIN_BITS),
    .IDXW       (IDXW),
    .BASE_ADDR  (BASE_ADDR)
  ) u_dec (
    .cmd_addr (cmd_addr),
    .hit      (dec_hit),
    .idx      (dec_idx)
  );

  // Only the slave latched at accept time is listened to.
  assign sel_ready = pready[idx_q];
  assign sel_err   = pslverr[idx_q];
  assign sel_rdata = prdata[int'(idx_q) * DATA_WIDTH +: DATA_WIDTH];

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state     <= IDLE;
      idx_q     <= '0;
      wcnt      <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      paddr     <= '0;
      psel      <= '0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
      pstrb     <= '0;
      pprot     <= '0;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_ready && cmd_valid) begin
            cmd_ready <= 1'b0;
            if (dec_hit) begin
              // APB request bus only moves on a real transfer; it holds otherwise.
              idx_q  <= dec_idx;
              paddr  <= cmd_addr;
              pwrite <= cmd_write;
              pwdata <= cmd_wdata;
              pstrb  <= cmd_write ? cmd_strb : '0;
              pprot  <= cmd_prot;
              psel   <= NUM_SLV'(1) << dec_idx;
              state  <= SETUP;
            end else begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
              state     <= RESP;
            end
          end
        end

        SETUP: begin
          penable <= 1'b1;
          wcnt    <= '0;
          state   <= ACCESS;
        end

        ACCESS: begin
          if (sel_ready || (wcnt == CNTW'(TIMEOUT - 1))) begin
            psel      <= '0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
            if (sel_ready) begin
              rsp_err   <= sel_err;
              rsp_rdata <= (!pwrite && !sel_err) ? sel_rdata : '0;
            end else begin
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_bridge_nport.sv
// Self-checking bench for apb_bridge_nport: vector table plus reset/hold sequences.
// Latency: n/a.
// Backpressure: rsp_ready held low on selected vectors.
module tb_apb_bridge_nport;

  localparam int NS = 4;
  localparam int DW = 32;
  localparam int AW = 32;

  logic             pclk = 1'b0;
  logic             presetn;
  logic             cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0]    cmd_addr;
  logic [DW-1:0]    cmd_wdata;
  logic [3:0]       cmd_strb;
  logic [2:0]       cmd_prot;
  logic             rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0]    rsp_rdata;
  logic [AW-1:0]    paddr;
  logic [NS-1:0]    psel;
  logic             penable, pwrite;
  logic [DW-1:0]    pwdata;
  logic [3:0]       pstrb;
  logic [2:0]       pprot;
  logic [NS*DW-1:0] prdata;
  logic [NS-1:0]    pready, pslverr;

  always #5 pclk = ~pclk;

  apb_bridge_nport dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .pstrb(pstrb), .pprot(pprot), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Slave models. Unselected slaves shout pready/pslverr=1 so any leak from
  // a non-selected port into the bridge shows up as a wrong response.
  int          s_wait [NS];   // wait states before pready; -1 = never ready
  bit          s_err  [NS];
  logic [31:0] s_rdata[NS];
  int          acc_run = 0;   // ACCESS cycles already spent in this transfer

  always @(posedge pclk)
    acc_run <= (penable && ((pready & psel) == '0)) ? acc_run + 1 : 0;

  always_comb begin
    pready  = '0;
    pslverr = '0;
    prdata  = '0;
    for (int i = 0; i < NS; i++) begin
      pready[i]           = psel[i] ? (penable && s_wait[i] >= 0 && acc_run >= s_wait[i]) : 1'b1;
      pslverr[i]          = psel[i] ? (pready[i] && s_err[i]) : 1'b1;
      prdata[i*DW +: DW]  = s_rdata[i];
    end
  end

  // Scoreboard and per-transaction bus monitor.
  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } rsp_t;
  rsp_t sb_q[$];

  int          cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  bit          mon_active = 0;
  int          acc_cyc, first_psel, first_pen, first_rsp, pen_cnt;
  logic [3:0]  psel_or;
  bit          bus_bad, prot_bad, rsp_done;
  logic [31:0] e_paddr, e_pwdata;
  logic [3:0]  e_pstrb;
  logic        e_pwrite;
  logic [2:0]  e_pprot;

  always @(negedge pclk) begin
    rsp_t e;
    if (mon_active) begin
      if (cmd_valid && cmd_ready) acc_cyc = cyc;
      if (psel != '0) begin
        if (first_psel < 0) first_psel = cyc;
        psel_or |= psel;
        if (!$onehot(psel)) prot_bad = 1;
        if (paddr !== e_paddr || pwrite !== e_pwrite || pwdata !== e_pwdata ||
            pstrb !== e_pstrb || pprot !== e_pprot) bus_bad = 1;
      end
      if (penable) begin
        pen_cnt++;
        if (first_pen < 0) first_pen = cyc;
        if (psel == '0) prot_bad = 1;
      end
      if (rsp_valid && psel != '0) prot_bad = 1;
      if (rsp_valid && first_rsp < 0) first_rsp = cyc;
      if (rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_unexpected_rsp: got err=%0b rdata=0x%0h, want no response", rsp_err, rsp_rdata);
        end else begin
          e = sb_q.pop_front();
          check("sb_rsp_err", 32'(rsp_err), 32'(e.err));
          check("sb_rsp_rdata", rsp_rdata, e.rdata);
        end
        rsp_done = 1;
      end
    end
  end

  typedef struct {
    bit          write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          slv;
    int          wait_c;
    bit          serr;
    logic [31:0] sdata;
    int          hold;       // cycles rsp_ready stays low after rsp_valid
    logic [3:0]  exp_psel;   // OR of all psel values seen
    int          exp_acc;    // penable-high cycles
    int          exp_lat;    // cycles from accept to first rsp_valid
    bit          exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  function automatic vec_t mk(bit w, logic [31:0] a, logic [31:0] wd, logic [3:0] st, logic [2:0] pr,
                              int slv, int wc, bit se, logic [31:0] sd, int hold,
                              logic [3:0] ep, int ea, int el, bit ee, logic [31:0] er);
    vec_t v;
    v.write = w;  v.addr = a;  v.wdata = wd;  v.strb = st;  v.prot = pr;
    v.slv = slv;  v.wait_c = wc;  v.serr = se;  v.sdata = sd;  v.hold = hold;
    v.exp_psel = ep;  v.exp_acc = ea;  v.exp_lat = el;  v.exp_err = ee;  v.exp_rdata = er;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    rsp_t e;
    bit   seen;
    bit   held_ok;
    @(posedge pclk); #1;
    for (int i = 0; i < NS; i++) begin
      s_wait[i]  = 0;
      s_err[i]   = 0;
      s_rdata[i] = 32'hFEED_0000 + i;
    end
    s_wait[v.slv]  = v.wait_c;
    s_err[v.slv]   = v.serr;
    s_rdata[v.slv] = v.sdata;
    e_paddr  = v.addr;
    e_pwrite = v.write;
    e_pwdata = v.wdata;
    e_pstrb  = v.write ? v.strb : 4'h0;
    e_pprot  = v.prot;
    acc_cyc = -1; first_psel = -1; first_pen = -1; first_rsp = -1; pen_cnt = 0;
    psel_or = '0; bus_bad = 0; prot_bad = 0; rsp_done = 0;
    rsp_ready = (v.hold == 0);
    e.err = v.exp_err;
    e.rdata = v.exp_rdata;
    sb_q.push_back(e);
    cmd_write = v.write; cmd_addr = v.addr; cmd_wdata = v.wdata;
    cmd_strb = v.strb; cmd_prot = v.prot; cmd_valid = 1'b1;
    mon_active = 1;

    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge pclk);
      seen = cmd_ready;
    end
    check({tag, "_accept"}, 32'(seen), 32'd1);
    @(posedge pclk); #1;
    cmd_valid = 1'b0;

    if (v.hold > 0) begin
      seen = 0;
      for (int k = 0; k < 40 && !seen; k++) begin
        @(negedge pclk);
        seen = rsp_valid;
      end
      held_ok = seen;
      for (int k = 0; k < v.hold; k++) begin
        if (!(rsp_valid && !cmd_ready && rsp_err === v.exp_err && rsp_rdata === v.exp_rdata))
          held_ok = 0;
        @(negedge pclk);
      end
      check({tag, "_rsp_held"}, 32'(held_ok), 32'd1);
      @(posedge pclk); #1;
      rsp_ready = 1'b1;
    end

    seen = 0;
    for (int k = 0; k < 80 && !seen; k++) begin
      @(posedge pclk);
      seen = rsp_done;
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_rsp_timeout: no response handshake within 80 cycles, want one", tag);
      sb_q.delete();
    end
    #1;
    mon_active = 0;

    check({tag, "_psel"}, 32'(psel_or), 32'(v.exp_psel));
    check({tag, "_access_cycles"}, 32'(pen_cnt), 32'(v.exp_acc));
    check({tag, "_rsp_latency"}, 32'(first_rsp - acc_cyc), 32'(v.exp_lat));
    check({tag, "_bus_stable"}, 32'(bus_bad), 32'd0);
    check({tag, "_protocol"}, 32'(prot_bad), 32'd0);
    if (v.exp_psel != '0) begin
      check({tag, "_psel_latency"}, 32'(first_psel - acc_cyc), 32'd1);
      check({tag, "_penable_latency"}, 32'(first_pen - acc_cyc), 32'd2);
    end
  endtask

  vec_t vecs[10];

  initial begin
    bit seen;
    presetn = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_strb = '0; cmd_prot = '0; rsp_ready = 1'b1;
    for (int i = 0; i < NS; i++) begin
      s_wait[i] = 0; s_err[i] = 0; s_rdata[i] = '0;
    end

    //          w  addr          wdata         strb  prot slv wait err sdata         hold  psel  acc lat err rdata
    vecs[0] = mk(1, 32'h4000_1004, 32'hDEAD_BEEF, 4'hF, 3'd0, 1,  0, 0, 32'h0,         0, 4'b0010,  1,  3, 0, 32'h0);
    vecs[1] = mk(0, 32'h4000_3010, 32'h0,         4'hF, 3'd0, 3,  3, 0, 32'h1234_5678, 0, 4'b1000,  4,  6, 0, 32'h1234_5678);
    vecs[2] = mk(0, 32'h5000_0000, 32'h0,         4'h0, 3'd0, 0,  0, 0, 32'h0,         0, 4'b0000,  0,  1, 1, 32'h0);
    vecs[3] = mk(0, 32'h4000_0000, 32'h0,         4'h0, 3'd0, 0, -1, 0, 32'hCAFE_0000, 0, 4'b0001, 16, 18, 1, 32'h0);
    vecs[4] = mk(0, 32'h4000_2008, 32'h0,         4'h0, 3'd0, 2,  1, 1, 32'hAAAA_5555, 5, 4'b0100,  2,  4, 1, 32'h0);
    vecs[5] = mk(1, 32'h4000_4000, 32'h1111_1111, 4'hF, 3'd0, 0,  0, 0, 32'h0,         0, 4'b0000,  0,  1, 1, 32'h0);
    vecs[6] = mk(0, 32'h4000_2FFC, 32'h0,         4'h0, 3'd5, 2,  0, 0, 32'h0BAD_F00D, 0, 4'b0100,  1,  3, 0, 32'h0BAD_F00D);
    vecs[7] = mk(1, 32'h4000_0010, 32'h0000_00A5, 4'h5, 3'd2, 0,  2, 0, 32'h7777_7777, 0, 4'b0001,  3,  5, 0, 32'h0);
    vecs[8] = mk(0, 32'h3FFF_FFFC, 32'h0,         4'h0, 3'd0, 0,  0, 0, 32'h0,         0, 4'b0000,  0,  1, 1, 32'h0);
    vecs[9] = mk(1, 32'h4000_3000, 32'h0F0F_0F0F, 4'hF, 3'd0, 3,  0, 1, 32'h0,         0, 4'b1000,  1,  3, 1, 32'h0);

    // Reset state.
    repeat (3) @(negedge pclk);
    check("reset_cmd_ready", 32'(cmd_ready), 32'd0);
    check("reset_psel", 32'(psel), 32'd0);
    check("reset_penable", 32'(penable), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_paddr", paddr, 32'd0);
    presetn = 1'b1;
    @(negedge pclk);
    check("release_cmd_ready", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 10; i++)
      run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of an ACCESS phase that would otherwise time out.
    @(posedge pclk); #1;
    for (int i = 0; i < NS; i++) begin
      s_wait[i] = 0; s_err[i] = 0;
    end
    s_wait[0] = -1;
    rsp_ready = 1'b1;
    cmd_write = 1'b0; cmd_addr = 32'h4000_0000; cmd_valid = 1'b1;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge pclk);
      seen = cmd_ready;
    end
    @(posedge pclk); #1;
    cmd_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge pclk);
      seen = penable;
    end
    check("rstmid_reached_access", 32'(seen), 32'd1);
    #2 presetn = 1'b0;
    #1;
    check("rstmid_psel", 32'(psel), 32'd0);
    check("rstmid_penable", 32'(penable), 32'd0);
    check("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rstmid_cmd_ready", 32'(cmd_ready), 32'd0);
    repeat (2) @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);
    check("rstmid_release_cmd_ready", 32'(cmd_ready), 32'd1);
    run_vec(mk(0, 32'h4000_1020, 32'h0, 4'h0, 3'd0, 1, 1, 0, 32'h5A5A_0001, 0,
               4'b0010, 2, 4, 0, 32'h5A5A_0001), "after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000 time units, want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
